// File: rtl/sar_search_pkg.sv
// sar_pkg: shared types for the successive-approximation search.
// State encoding and the {agb,alb,aeb} flag-vector constants.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FIN
  } state_t;

  localparam int SAR_WIDTH = 8;
  localparam int IDX_W = $clog2(SAR_WIDTH);

  typedef logic [2:0] flags_t;

  localparam flags_t GT = 3'b100;
  localparam flags_t LT = 3'b010;
  localparam flags_t EQ = 3'b001;

endpackage

// File: rtl/sar_search.sv
// sar_search: MSB-first successive-approximation initiator.
// Proposes trials to a comparator and folds gt/lt/eq into a result.
import sar_pkg::*;

module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  output logic             cmp_req,
  input  logic             cmp_valid,
  input  logic             agb,
  input  logic             alb,
  input  logic             aeb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);

  state_t           state;
  logic [IW-1:0]    idx;
  flags_t           flags;
  logic [WIDTH-1:0] bitm;
  logic [WIDTH-1:0] tkeep;
  logic             accept;

  // Resolve the bit under test: clear it on lt, keep it otherwise
  always_comb begin
    flags  = {agb, alb, aeb};
    bitm   = WIDTH'(1) << idx;
    tkeep  = (flags == LT) ? (trial & ~bitm) : trial;
    accept = cmp_valid && !cmp_req;
  end

  // Search FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      trial   <= '0;
      cmp_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      found   <= 1'b0;
      err     <= 1'b0;
    end else begin
      cmp_req <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            trial   <= WIDTH'(1) << (WIDTH - 1);
            idx     <= IW'(WIDTH - 1);
            cmp_req <= 1'b1;
            busy    <= 1'b1;
            found   <= 1'b0;
            err     <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (accept) begin
            unique case (flags)
              EQ: begin
                found  <= 1'b1;
                result <= trial;
                busy   <= 1'b0;
                done   <= 1'b1;
                state  <= FIN;
              end
              GT, LT: begin
                if (idx == '0) begin
                  result <= tkeep;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= FIN;
                end else begin
                  trial   <= tkeep | (bitm >> 1);
                  idx     <= idx - 1'b1;
                  cmp_req <= 1'b1;
                end
              end
              default: begin
                err    <= 1'b1;
                result <= trial;
                busy   <= 1'b0;
                done   <= 1'b1;
                state  <= FIN;
              end
            endcase
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
